// File: rtl/cpu_types_pkg.sv
// Shared CPU/bus types: RAM handshake states and coherence bus controller states.
package cpu_types_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BLK_WORD_OFF = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE,
    IFETCH,
    WB0,
    WB1,
    INV,
    INV_ACK,
    SNP_SET,
    SNP_RESP,
    C2C0,
    C2C1,
    RD0,
    RD1
  } bus_state_t;

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer toggles whenever a grant is consumed.
module rr_arbiter (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       gnt_valid_c,
  output logic       gnt_idx_c
);

  logic rr;

  // First requester at or after the pointer wins.
  always_comb begin
    gnt_valid_c = |req;
    gnt_idx_c   = req[rr] ? rr : ~rr;
  end

  // Pointer flips after every granted data transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)    rr <= 1'b0;
    else if (adv) rr <= ~rr;
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Memory-side bus and coherence controller for two cores sharing one RAM port.
// Optional build macro COHERENCE_STATS_EN adds c2c/ramfill/inv event counters.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned RAM_AW = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0][31:0]  iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        cctrans,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [RAM_AW-1:0]      ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  ramstate_t              ramstate
`ifdef COHERENCE_STATS_EN
  ,
  output logic [31:0]            c2c_cnt,
  output logic [31:0]            ramfill_cnt,
  output logic [31:0]            inv_cnt
`endif
);

  bus_state_t    state, state_nx;
  logic          owner, owner_nx;
  word_t         base, base_nx;
  logic          other;
  logic          done;
  logic          gnt_valid, gnt_idx, arb_adv;
  logic [CPUS-1:0] dreq;
  word_t         snp_addr;

  assign other    = ~owner;
  assign done     = (ramstate == ACCESS);
  assign dreq     = dREN | dWEN | ccwrite;
  assign arb_adv  = (state == IDLE) && gnt_valid;
  assign snp_addr = base + ((state == C2C1) ? WORD_W'(BLK_WORD_OFF) : WORD_W'(0));

  rr_arbiter u_arb (
    .CLK         (CLK),
    .nRST        (nRST),
    .req         (dreq),
    .adv         (arb_adv),
    .gnt_valid_c (gnt_valid),
    .gnt_idx_c   (gnt_idx)
  );

  // State, owner and snoop block base registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= 1'b0;
      base  <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      base  <= base_nx;
    end
  end

  // Next-state and bus/handshake outputs; ERROR and BUSY simply hold.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    base_nx     = base;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          owner_nx = gnt_idx;
          if (dWEN[gnt_idx])         state_nx = WB0;
          else if (ccwrite[gnt_idx]) state_nx = INV;
          else begin
            state_nx = SNP_SET;
            base_nx  = {daddr[gnt_idx][31:3], 3'b000};
          end
        end else if (|iREN) begin
          owner_nx = iREN[0] ? 1'b0 : 1'b1;
          state_nx = IFETCH;
        end
      end
      IFETCH: begin
        ramREN       = 1'b1;
        ramaddr      = RAM_AW'(iaddr[owner]);
        iload[owner] = ramload;
        if (done) begin
          iwait[owner] = 1'b0;
          state_nx     = IDLE;
        end
      end
      WB0, WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = RAM_AW'(daddr[owner]);
        ramstore = dstore[owner];
        if (done) begin
          dwait[owner] = 1'b0;
          state_nx     = (state == WB0) ? WB1 : IDLE;
        end
      end
      INV: begin
        ccwait[other]      = 1'b1;
        ccinv[other]       = 1'b1;
        ccsnoopaddr[other] = daddr[owner];
        state_nx           = INV_ACK;
      end
      INV_ACK: begin
        ccinv[owner] = 1'b1;
        dwait[owner] = 1'b0;
        state_nx     = IDLE;
      end
      SNP_SET: begin
        ccwait[other]      = 1'b1;
        ccsnoopaddr[other] = base;
        state_nx           = SNP_RESP;
      end
      SNP_RESP: begin
        ccwait[other]      = 1'b1;
        ccsnoopaddr[other] = base;
        state_nx           = cctrans[other] ? C2C0 : RD0;
      end
      C2C0, C2C1: begin
        ccwait[other]      = 1'b1;
        ccsnoopaddr[other] = snp_addr;
        dload[owner]       = dstore[other];
        ramWEN             = 1'b1;
        ramaddr            = RAM_AW'(snp_addr);
        ramstore           = dstore[other];
        if (done) begin
          dwait[owner] = 1'b0;
          state_nx     = (state == C2C0) ? C2C1 : IDLE;
        end
      end
      RD0, RD1: begin
        ramREN       = 1'b1;
        ramaddr      = RAM_AW'(daddr[owner]);
        dload[owner] = ramload;
        if (done) begin
          dwait[owner] = 1'b0;
          state_nx     = (state == RD0) ? RD1 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef COHERENCE_STATS_EN
  // Event counters for cache-to-cache transfers, RAM fills and invalidations.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c2c_cnt     <= '0;
      ramfill_cnt <= '0;
      inv_cnt     <= '0;
    end else begin
      if (state == C2C1 && done) c2c_cnt     <= c2c_cnt + 32'd1;
      if (state == RD1 && done)  ramfill_cnt <= ramfill_cnt + 32'd1;
      if (state == INV)          inv_cnt     <= inv_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl with a small latency-configurable RAM model.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;
`ifdef COHERENCE_STATS_EN
  logic [31:0]      c2c_cnt, ramfill_cnt, inv_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int lat_cfg = 2;
  int ram_cnt = 0;
  logic [63:0] wlog[$];

  always #5 CLK = ~CLK;

  coherence_bus_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans), .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef COHERENCE_STATS_EN
    , .c2c_cnt(c2c_cnt), .ramfill_cnt(ramfill_cnt), .inv_cnt(inv_cnt)
`endif
  );

  // RAM model: ACCESS after lat_cfg cycles of a held request; read data tagged by address.
  always_comb begin
    if (ramREN || ramWEN) ramstate = (ram_cnt >= lat_cfg - 1) ? ACCESS : BUSY;
    else                  ramstate = FREE;
    ramload = 32'hAAAA0000 | {24'h0, ramaddr[7:0]};
  end

  always @(posedge CLK) begin
    if (!(ramREN || ramWEN) || ramstate == ACCESS) ram_cnt <= 0;
    else                                            ram_cnt <= ram_cnt + 1;
    if (nRST && ramstate == ACCESS && ramWEN) wlog.push_back({ramaddr, ramstore});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Acts as core c's dcache for one two-word block read or writeback.
  task automatic xfer(input int c, input bit wr, input logic [31:0] base,
                      input logic [31:0] v0, input logic [31:0] v1,
                      output logic [31:0] dl0, output logic [31:0] dl1,
                      output logic [31:0] sa0, output logic [31:0] sa1,
                      output int ccw_other, output int ccw_own,
                      output int busy_n, output int busy_bad, output bit to);
    int o = 1 - c;
    int n = 0;
    int adv = 0;
    bit fin = 0;
    dl0 = '0; dl1 = '0; sa0 = '0; sa1 = '0;
    ccw_other = 0; ccw_own = 0; busy_n = 0; busy_bad = 0;
    daddr[c] = base;
    if (wr) begin dWEN[c] = 1'b1; dstore[c] = v0; end
    else    begin dREN[c] = 1'b1; dstore[o] = v0; end
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      @(posedge CLK); #1;
      if (adv == 1) begin
        daddr[c] = base + 32'd4;
        if (wr) dstore[c] = v1; else dstore[o] = v1;
      end
      if (adv == 2) begin
        dREN[c] = 1'b0; dWEN[c] = 1'b0; fin = 1;
      end
      adv = 0;
      #1;
      if (!fin) begin
        if (ccwait[o]) ccw_other++;
        if (ccwait[c]) ccw_own++;
        if (ramstate == BUSY) begin
          busy_n++;
          if (!dwait[c]) busy_bad++;
        end
        if (!dwait[c]) begin
          if (n == 0) begin dl0 = dload[c]; sa0 = ccsnoopaddr[o]; end
          else        begin dl1 = dload[c]; sa1 = ccsnoopaddr[o]; end
          n++;
          adv = n;
        end
      end
    end
    to = (n < 2);
  endtask

  logic [31:0] dl0, dl1, sa0, sa1;
  int ccwo, ccwn, bn, bb;
  bit to;

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_iwait",   32'(iwait), 32'h3);
    check("rst_dwait",   32'(dwait), 32'h3);
    check("rst_ccwait",  32'(ccwait), 32'h0);
    check("rst_ramstb",  32'({ramREN, ramWEN}), 32'h0);
    check("rst_dload0",  dload[0], 32'h0);
    nRST = 1'b1;

    // Block read with clean snoop
    wlog.delete();
    xfer(0, 1'b0, 32'h100, 32'h0, 32'h0, dl0, dl1, sa0, sa1, ccwo, ccwn, bn, bb, to);
    check("t1_done",     32'(to), 32'h0);
    check("t1_ccw1_cyc", 32'(ccwo), 32'd2);
    check("t1_ccw_own",  32'(ccwn), 32'd0);
    check("t1_dload0",   dl0, 32'hAAAA0000);
    check("t1_dload1",   dl1, 32'hAAAA0004);
    check("t1_nowrite",  32'(wlog.size()), 32'd0);

    // Cache-to-cache transfer from dirty core1
    wlog.delete();
    cctrans[1] = 1'b1;
    xfer(0, 1'b0, 32'h200, 32'hDEAD, 32'hBEEF, dl0, dl1, sa0, sa1, ccwo, ccwn, bn, bb, to);
    cctrans[1] = 1'b0;
    check("t2_done",    32'(to), 32'h0);
    check("t2_dload0",  dl0, 32'hDEAD);
    check("t2_dload1",  dl1, 32'hBEEF);
    check("t2_snp0",    sa0, 32'h200);
    check("t2_snp1",    sa1, 32'h204);
    check("t2_ccw_cyc", 32'(ccwo), 32'd6);
    check("t2_ccw_own", 32'(ccwn), 32'd0);
    check("t2_wcount",  32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t2_wr0_addr", wlog[0][63:32], 32'h200);
      check("t2_wr0_data", wlog[0][31:0],  32'hDEAD);
      check("t2_wr1_addr", wlog[1][63:32], 32'h204);
      check("t2_wr1_data", wlog[1][31:0],  32'hBEEF);
    end

    // Write-hit invalidation from core1
    ccwrite[1] = 1'b1; daddr[1] = 32'h308;
    @(posedge CLK); #2;
    check("t3_inv_ccwait0", 32'(ccwait[0]), 32'h1);
    check("t3_inv_ccinv0",  32'(ccinv[0]), 32'h1);
    check("t3_inv_addr0",   ccsnoopaddr[0], 32'h308);
    check("t3_inv_ccwait1", 32'(ccwait[1]), 32'h0);
    check("t3_inv_dwait1",  32'(dwait[1]), 32'h1);
    @(posedge CLK); #2;
    check("t3_ack_ccinv1",  32'(ccinv[1]), 32'h1);
    check("t3_ack_ccwait1", 32'(ccwait[1]), 32'h0);
    check("t3_ack_dwait1",  32'(dwait[1]), 32'h0);
    check("t3_ack_ccwait0", 32'(ccwait[0]), 32'h0);
    ccwrite[1] = 1'b0;

    // Writeback through a RAM that is BUSY for 3 cycles per word
    wlog.delete();
    lat_cfg = 4;
    xfer(0, 1'b1, 32'h400, 32'h11, 32'h22, dl0, dl1, sa0, sa1, ccwo, ccwn, bn, bb, to);
    lat_cfg = 2;
    check("t4_done",     32'(to), 32'h0);
    check("t4_busy_cyc", 32'(bn), 32'd6);
    check("t4_busy_wait", 32'(bb), 32'd0);
    check("t4_wcount",   32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t4_wr0", wlog[0][63:32] ^ wlog[0][31:0], 32'h400 ^ 32'h11);
      check("t4_wr0_addr", wlog[0][63:32], 32'h400);
      check("t4_wr1_addr", wlog[1][63:32], 32'h404);
      check("t4_wr1_data", wlog[1][31:0],  32'h22);
    end

    // Simultaneous reads from both cores, twice each, with a pending fetch on core0
    begin
      int order[$];
      int txn[2];
      int wd[2];
      bit pend[2];
      bit pw0 = 0, pw1 = 0;
      bit got_if = 0, if_pend = 0, t5_done = 0;
      int if_grants = -1;
      logic [31:0] il = '0, ia = '0;
      logic [31:0] b5[2];
      int g[4];
      b5[0] = 32'h700; b5[1] = 32'h800;
      txn[0] = 0; txn[1] = 0; wd[0] = 0; wd[1] = 0; pend[0] = 0; pend[1] = 0;
      daddr[0] = b5[0]; daddr[1] = b5[1];
      dREN = 2'b11; iREN[0] = 1'b1; iaddr[0] = 32'h51C;
      for (int cyc = 0; cyc < 300 && !t5_done; cyc++) begin
        @(posedge CLK); #1;
        for (int c = 0; c < 2; c++) begin
          if (pend[c]) begin
            wd[c]++;
            if (wd[c] == 2) begin wd[c] = 0; txn[c]++; end
            if (txn[c] == 2) dREN[c] = 1'b0;
            daddr[c] = b5[c] + 32'(txn[c] * 8 + wd[c] * 4);
            pend[c] = 0;
          end
        end
        if (if_pend) begin iREN[0] = 1'b0; t5_done = 1; end
        #1;
        if (!t5_done) begin
          if (ccwait[1] && !pw1) order.push_back(0);
          if (ccwait[0] && !pw0) order.push_back(1);
          pw0 = ccwait[0]; pw1 = ccwait[1];
          if (!iwait[0] && !got_if) begin
            got_if = 1; if_pend = 1;
            if_grants = order.size(); il = iload[0]; ia = ramaddr;
          end
          for (int c = 0; c < 2; c++) if (!dwait[c]) pend[c] = 1;
        end
      end
      for (int i = 0; i < 4; i++) g[i] = (i < order.size()) ? order[i] : 9;
      check("t5_done",   32'(t5_done), 32'h1);
      check("t5_ngrant", 32'(order.size()), 32'd4);
      check("t5_grant0", 32'(g[0]), 32'd0);
      check("t5_grant1", 32'(g[1]), 32'd1);
      check("t5_grant2", 32'(g[2]), 32'd0);
      check("t5_grant3", 32'(g[3]), 32'd1);
      check("t5_if_after", 32'(if_grants), 32'd4);
      check("t5_iload",  il, 32'hAAAA001C);
      check("t5_iaddr",  ia, 32'h51C);
    end

`ifdef COHERENCE_STATS_EN
    check("st_c2c",     c2c_cnt,     32'd1);
    check("st_ramfill", ramfill_cnt, 32'd5);
    check("st_inv",     inv_cnt,     32'd1);
`endif

    // Reset in the middle of C2C1
    begin
      bit hit = 0, padv = 0;
      cctrans[1] = 1'b1; dstore[1] = 32'h1234;
      dREN[0] = 1'b1; daddr[0] = 32'h600;
      for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
        @(posedge CLK); #1;
        if (padv) begin daddr[0] = 32'h604; dstore[1] = 32'h5678; padv = 0; end
        #1;
        if (!dwait[0]) padv = 1;
        if (ccwait[1] && ccsnoopaddr[1] == 32'h604) hit = 1;
      end
      check("t6_reach_c2c1", 32'(hit), 32'h1);
      nRST = 1'b0;
      #1;
      check("t6_iwait",   32'(iwait), 32'h3);
      check("t6_dwait",   32'(dwait), 32'h3);
      check("t6_dload0",  dload[0], 32'h0);
      check("t6_ccwait",  32'(ccwait), 32'h0);
      check("t6_ccinv",   32'(ccinv), 32'h0);
      check("t6_snp1",    ccsnoopaddr[1], 32'h0);
      check("t6_ramstb",  32'({ramREN, ramWEN}), 32'h0);
      check("t6_ramaddr", ramaddr, 32'h0);
      check("t6_ramstore", ramstore, 32'h0);
`ifdef COHERENCE_STATS_EN
      check("t6_c2c_cnt", c2c_cnt, 32'd0);
`endif
      dREN = '0; cctrans = '0;
      @(negedge CLK); nRST = 1'b1;
      @(posedge CLK); #2;
      check("t6_idle_ram",  32'({ramREN, ramWEN}), 32'h0);
      check("t6_idle_ccw",  32'(ccwait), 32'h0);
      check("t6_idle_dwait", 32'(dwait), 32'h3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Bus and coherence controller on the memory side of the per-core caches.
- Arbitrates instruction fetches, data-cache block reads/writebacks and write-hit invalidations from CPUS cores onto one RAM port.
- Snoops the non-requesting data cache, performing cache-to-cache transfer when that cache holds the block dirty.
- It is the responder end of the dREN/dWEN/ccwrite/cctrans/ccwait/ccinv/ccsnoopaddr protocol that the dcache drives.

Parameters:
- CPUS, 2, number of cores; logic is written for exactly 2 (the "other" core is 1-req).
- RAM_AW, 32, RAM word-address width; addresses are byte addresses, word aligned.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- iREN  in  CPUS  instruction fetch request, per core
- iaddr  in  CPUSx32  fetch address
- iwait  out  CPUS  1 = fetch not yet done
- iload  out  CPUSx32  fetch data
- dREN  in  CPUS  data word read (block fill)
- dWEN  in  CPUS  data word write (writeback)
- daddr  in  CPUSx32  data address
- dstore  in  CPUSx32  writeback data; also snoop response data
- ccwrite  in  CPUS  write-hit invalidation request, address on daddr
- cctrans  in  CPUS  snoop response: 1 = snooped block valid and dirty
- dwait  out  CPUS  1 = data access not yet done
- dload  out  CPUSx32  read data
- ccwait  out  CPUS  snoop in progress on that cache
- ccinv  out  CPUS  with ccwait: invalidate snooped block; without ccwait: invalidation acknowledge
- ccsnoopaddr  out  CPUSx32  snooped address
- ramREN, ramWEN  out  1  RAM strobes
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE / BUSY / ACCESS / ERROR (cpu_types_pkg); ACCESS = transfer completes this cycle

Behaviour:
- Interface: reset nRST, asynchronous, active-low; clock CLK.
- Reset values: state IDLE, owner 0, rr 0.
  - All iwait and dwait are 1; iload and dload are 0.
  - ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr and ramstore are all 0.
- Outputs are combinational from state and registers. dwait and iwait are 1 except in the cycle a transfer completes.
- Arbitration in IDLE:
  - Data requests (dREN, dWEN or ccwrite) beat iREN.
  - Among cores, round-robin pointer rr picks the first requester starting at rr. rr toggles after each granted data transaction.
  - iREN is served by the lowest-indexed requesting core when no data request exists.
- IDLE:
  - dWEN goes to WB0.
  - ccwrite goes to INV.
  - dREN goes to SNP_SET; latch owner and block base {daddr[31:3],3'b0}.
  - iREN goes to IFETCH.
- IFETCH:
  - ramREN=1, ramaddr=iaddr.
  - On ACCESS: iwait[owner]=0, iload=ramload, go to IDLE.
- WB0 / WB1: ramWEN=1, ramaddr=daddr[owner], ramstore=dstore[owner]. On ACCESS, dwait=0; WB0 goes to WB1, WB1 goes to IDLE.
- INV:
  - One cycle: ccwait[other]=1, ccinv[other]=1, ccsnoopaddr[other]=daddr[owner].
  - Next cycle (INV_ACK): ccinv[owner]=1, ccwait[owner]=0, dwait[owner]=0, then IDLE.
- SNP_SET:
  - ccwait[other]=1, ccinv[other]=0, ccsnoopaddr[other]=base.
  - Held exactly one cycle because the dcache registers the snoop address; then SNP_RESP.
- SNP_RESP: ccwait still held.
  - cctrans[other]=1 goes to C2C0.
  - Otherwise RD0; ccwait drops when entering RD0.
- C2C0 / C2C1:
  - ccwait[other]=1, ccsnoopaddr = base + 0 (C2C0) or base + 4 (C2C1).
  - dload[owner]=dstore[other].
  - The same word is copied to RAM: ramWEN=1, ramaddr=snoop address, ramstore=dstore[other].
  - On ACCESS: dwait[owner]=0; C2C0 goes to C2C1, C2C1 goes to IDLE.
  - The snooped copy stays valid.
- RD0 / RD1: ramREN=1, ramaddr=daddr[owner], dload[owner]=ramload. On ACCESS, dwait=0; RD0 goes to RD1, RD1 goes to IDLE.
- Boundary conditions:
  - ramstate ERROR or BUSY is treated as not done: hold state and outputs.
  - A requester dropping its request mid-transaction is illegal and not checked.
  - Simultaneous dREN from both cores is serialised by rr.
  - A snoop of a core that is itself waiting is allowed; its snoop logic is independent of its miss FSM.
  - Reset mid-transaction aborts to IDLE with reset outputs. No partial RAM write is retried.
- Guarantee: ccwait is never asserted to the owner.

Optional Feature:
- COHERENCE_STATS_EN compiled in:
  - Adds 32-bit output counters c2c_cnt (incremented on C2C1 completion), ramfill_cnt (RD1 completion) and inv_cnt (INV).
  - Counters reset to 0 and wrap at 2^32.
- Compiled out: the counter ports and logic are absent, with no other change.

Decomposition:
- Add to cpu_types_pkg:
  - bus_state_t enum: IDLE, IFETCH, WB0, WB1, INV, INV_ACK, SNP_SET, SNP_RESP, C2C0, C2C1, RD0, RD1.
  - BLK_WORD_OFF constant = 4.
- Reuses ramstate_t from the same package.
- One sub-module: rr_arbiter (2-way round-robin grant with pointer update).

Test Plan:
- Core0 dREN at 0x100, core1 cctrans=0, RAM latency 2:
  - ccwait[1]=1 for exactly 2 cycles (SNP_SET, SNP_RESP), then 2 RAM reads at 0x100 and 0x104.
  - dload[0] returns 0xAAAA0000 then 0xAAAA0004.
- Core0 dREN at 0x200, core1 cctrans=1 with dstore 0xDEAD/0xBEEF:
  - dload[0] gets 0xDEAD then 0xBEEF.
  - RAM is written at 0x200 and 0x204.
  - ccsnoopaddr[1] steps 0x200 then 0x204.
- Core1 ccwrite at 0x308:
  - One cycle with ccwait[0]=ccinv[0]=1 and ccsnoopaddr[0]=0x308.
  - Next cycle ccinv[1]=1, ccwait[1]=0.
- Both cores dREN in the same cycle, then again:
  - Grant order 0, 1, 0, 1.
  - iREN[0], asserted throughout, is served only after both data transactions.
- Core0 dWEN 0x400/0x404 with 0x11/0x22 while ramstate is BUSY for 3 cycles:
  - dwait stays 1 during BUSY; RAM receives both words in order.
- nRST asserted during C2C1:
  - All outputs go to their reset values immediately and the state is IDLE.
  - With COHERENCE_STATS_EN, c2c_cnt = 0.
